// File: rtl/bram_addr_arbiter_pkg.sv
// Shared widths, state encoding, owner constants and the round-robin pick
// used by the BRAM address arbiter.
package bram_addr_arbiter_pkg;

    localparam int ADDR_W = 14;
    localparam int LEN_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam logic OWN0 = 1'b0;
    localparam logic OWN1 = 1'b1;

    // Requester 1 wins when it is alone, or when both ask and 0 was served last.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        return (req1 && (!req0 || (last == OWN0))) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/bram_addr_arbiter_if.sv
// Requester/BRAM-port bundle of the address arbiter plus a debug view of its FSM.
interface bram_addr_arbiter_if;
    import bram_addr_arbiter_pkg::*;

    // Handshake: a requester raises reqN with baseN/lenN stable and holds them
    // until gntN pulses for one cycle; it must drop reqN once gntN is seen.
    // doneN pulses on the last beat (or together with gntN for a zero-length burst).
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] base0;
    logic [ADDR_W-1:0] base1;
    logic [LEN_W-1:0]  len0;
    logic [LEN_W-1:0]  len1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [ADDR_W-1:0] mem_addr;
    logic              rd_en;
    logic              sel;
    logic              rd_valid;
    logic              rd_owner;
    logic              busy;
    arb_state_e        dbg_state;

    modport master (
        output req0, req1, base0, base1, len0, len1,
        input  gnt0, gnt1, done0, done1, mem_addr, rd_en, sel,
               rd_valid, rd_owner, busy, dbg_state
    );

    modport slave (
        input  req0, req1, base0, base1, len0, len1,
        output gnt0, gnt1, done0, done1, mem_addr, rd_en, sel,
               rd_valid, rd_owner, busy, dbg_state
    );

endinterface

// File: rtl/bram_addr_arbiter_addr_burst_counter.sv
// Burst address walker: latches base/len on load, advances one beat per step,
// and flags the current and the upcoming last beat.
module addr_burst_counter
    import bram_addr_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              last,
    output logic              next_last
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  count_inc;
    logic [LEN_W-1:0]  len_m1;

    always_comb begin
        base_d    = base_q;
        len_d     = len_q;
        count_d   = count_q;
        addr_d    = addr_q;
        count_inc = count_q + LEN_W'(1);
        len_m1    = len_q - LEN_W'(1);
        if (load) begin
            base_d  = base_in;
            len_d   = len_in;
            count_d = '0;
            addr_d  = base_in;
        end else if (step) begin
            count_d = count_inc;
            // Address arithmetic is modulo 2^ADDR_W, so 0x3FFF rolls to 0x0000.
            addr_d  = base_q + {{(ADDR_W-LEN_W){1'b0}}, count_inc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
        end else begin
            base_q  <= base_d;
            len_q   <= len_d;
            count_q <= count_d;
            addr_q  <= addr_d;
        end
    end

    assign mem_addr  = addr_q;
    assign last      = (count_q == len_m1);
    assign next_last = (count_inc == len_m1);

endmodule

// File: rtl/bram_addr_arbiter.sv
// Two-requester round-robin arbiter for one BRAM read port: grants bursts,
// sequences beat addresses and returns a read-valid aligned to 1-cycle latency.
module bram_addr_arbiter
    import bram_addr_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    bram_addr_arbiter_if.slave   bus
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              sel_q, sel_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_owner_q, rd_owner_d;

    logic              winner;
    logic [ADDR_W-1:0] win_base;
    logic [LEN_W-1:0]  win_len;
    logic              cnt_load;
    logic              cnt_step;
    logic              cnt_last;
    logic              cnt_next_last;
    logic [ADDR_W-1:0] cnt_addr;

    addr_burst_counter u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cnt_load),
        .step      (cnt_step),
        .base_in   (win_base),
        .len_in    (win_len),
        .mem_addr  (cnt_addr),
        .last      (cnt_last),
        .next_last (cnt_next_last)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        sel_d      = sel_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        cnt_load   = 1'b0;
        cnt_step   = 1'b0;
        winner     = rr_pick(bus.req0, bus.req1, last_q);
        win_base   = (winner == OWN1) ? bus.base1 : bus.base0;
        win_len    = (winner == OWN1) ? bus.len1 : bus.len0;
        rd_valid_d = (state_q == BURST);
        rd_owner_d = sel_q;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    sel_d  = winner;
                    gnt0_d = (winner == OWN0);
                    gnt1_d = (winner == OWN1);
                    if (win_len == '0) begin
                        // Zero-length burst: acknowledge and finish in one cycle.
                        done0_d = (winner == OWN0);
                        done1_d = (winner == OWN1);
                        last_d  = winner;
                    end else begin
                        state_d  = BURST;
                        cnt_load = 1'b1;
                        done0_d  = (win_len == LEN_W'(1)) && (winner == OWN0);
                        done1_d  = (win_len == LEN_W'(1)) && (winner == OWN1);
                    end
                end
            end
            BURST: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                end else begin
                    cnt_step = 1'b1;
                    done0_d  = cnt_next_last && (sel_q == OWN0);
                    done1_d  = cnt_next_last && (sel_q == OWN1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= OWN1;
            sel_q      <= OWN0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rd_valid_q <= rd_valid_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.mem_addr  = cnt_addr;
    assign bus.rd_en     = (state_q == BURST);
    assign bus.busy      = (state_q == BURST);
    assign bus.sel       = sel_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_owner  = rd_owner_q;
    assign bus.dbg_state = state_q;

endmodule
